// File: rtl/counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared state encoding and default width for the up/down
//                loadable counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

   localparam int COUNTER_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/ripple_incrementer.sv
// ============================================================================
//  Module      : ripple_incrementer
//  Description : Combinational a+1 built from a chain of half adders, with
//                carry-out. Isolated so alternative adder cells can replace it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_incrementer #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   logic [WIDTH:0] w_carry;

   assign w_carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_sum[i]     = i_a[i] ^ w_carry[i];
      assign w_carry[i+1] = i_a[i] & w_carry[i];
   end

   assign o_carry = w_carry[WIDTH];

endmodule : ripple_incrementer

`default_nettype wire

// File: rtl/up_counter_match.sv
// ============================================================================
//  Module      : up_counter_match
//  Description : Latches a target, counts up from zero on each inc pulse and
//                flags match when the count reaches the target.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_counter_match
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             latch,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             match
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] target_q, target_d;

   logic [WIDTH-1:0] w_inc_operand;
   logic [WIDTH-1:0] w_inc_sum;
   logic             w_inc_carry;

   // Only COUNT ever consumes the sum, and there count < target, so gating the
   // operand elsewhere keeps the carry-out permanently low.
   assign w_inc_operand = (state_q == ST_COUNT) ? count_q : '0;

   ripple_incrementer #(
      .WIDTH (WIDTH)
   ) u_inc (
      .i_a     (w_inc_operand),
      .o_sum   (w_inc_sum),
      .o_carry (w_inc_carry)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      if (latch) begin
         target_d = in;
         count_d  = '0;
         state_d  = (in == '0) ? ST_DONE : ST_COUNT;
      end else if (clear) begin
         count_d = '0;
         state_d = ST_IDLE;
      end else if (state_q == ST_COUNT && inc) begin
         count_d = w_inc_sum;
         if (w_inc_sum == target_q) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
      end
   end

   assign count     = count_q;
   assign remaining = target_q - count_q;
   assign busy      = (state_q == ST_COUNT);
   assign match     = (state_q == ST_DONE);

   a_no_inc_carry : assert property (@(posedge clock) disable iff (!reset_n) !w_inc_carry);

endmodule : up_counter_match

`default_nettype wire

// File: tb/tb_up_counter_match.sv
// ============================================================================
//  Module      : tb_up_counter_match
//  Description : Directed self-checking bench for up_counter_match.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_counter_match;

   localparam int WIDTH = 32;

   logic             clock;
   logic             reset_n;
   logic [WIDTH-1:0] in;
   logic             latch;
   logic             inc;
   logic             clear;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] remaining;
   logic             busy;
   logic             match;

   int n_vec;
   int n_miss;
   bit carry_seen;

   up_counter_match #(
      .WIDTH (WIDTH)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in        (in),
      .latch     (latch),
      .inc       (inc),
      .clear     (clear),
      .count     (count),
      .remaining (remaining),
      .busy      (busy),
      .match     (match)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (dut.w_inc_carry) carry_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] c, input logic [31:0] r,
                            input logic b, input logic m);
      check({tag, ".count"},     count,     c);
      check({tag, ".remaining"}, remaining, r);
      check({tag, ".busy"},      {31'd0, busy},  {31'd0, b});
      check({tag, ".match"},     {31'd0, match}, {31'd0, m});
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      carry_seen = 1'b0;
      reset_n    = 1'b0;
      in         = 32'd5;
      latch      = 1'b1;
      inc        = 1'b1;
      clear      = 1'b0;

      // Reset held with latch/inc active: nothing moves
      #1;
      check_all("rst0", 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("rst_edge", 0, 0, 0, 0);
      end

      // Basic count to 5
      reset_n = 1'b1;
      inc     = 1'b0;
      tick();
      check_all("latch5", 0, 5, 1, 0);
      latch = 1'b0;
      inc   = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_all("cnt5", i, 5 - i, (i < 5), (i == 5));
      end
      tick();
      check_all("cnt5_hold", 5, 0, 0, 1);

      // Zero target
      latch = 1'b1;
      in    = 32'd0;
      tick();
      check_all("zero_latch", 0, 0, 0, 1);
      latch = 1'b0;
      tick();
      tick();
      check_all("zero_inc", 0, 0, 0, 1);

      // Priority: latch beats clear and inc
      latch = 1'b1;
      in    = 32'd10;
      inc   = 1'b0;
      tick();
      latch = 1'b0;
      inc   = 1'b1;
      tick();
      tick();
      tick();
      check_all("pri_pre", 3, 7, 1, 0);
      latch = 1'b1;
      clear = 1'b1;
      in    = 32'h5555_5555;
      tick();
      check_all("pri_latch", 0, 32'h5555_5555, 1, 0);
      latch = 1'b0;
      inc   = 1'b0;
      tick();
      check_all("pri_clear", 0, 32'h5555_5555, 0, 0);
      clear = 1'b0;
      inc   = 1'b1;
      tick();
      check_all("idle_inc", 0, 32'h5555_5555, 0, 0);

      // Boundary: all-ones target reached without wrap
      latch = 1'b1;
      in    = 32'hFFFF_FFFF;
      inc   = 1'b0;
      tick();
      latch = 1'b0;
      force dut.count_q = 32'hFFFF_FFFD;
      #1;
      release dut.count_q;
      check_all("bnd_pre", 32'hFFFF_FFFD, 2, 1, 0);
      inc = 1'b1;
      tick();
      check_all("bnd_1", 32'hFFFF_FFFE, 1, 1, 0);
      tick();
      check_all("bnd_2", 32'hFFFF_FFFF, 0, 0, 1);
      tick();
      check_all("bnd_hold", 32'hFFFF_FFFF, 0, 0, 1);

      // Async reset mid-count
      latch = 1'b1;
      in    = 32'd20;
      inc   = 1'b0;
      tick();
      latch = 1'b0;
      inc   = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check_all("ar_pre", 7, 13, 1, 0);
      inc = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_all("ar_async", 0, 0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;
      inc     = 1'b1;
      tick();
      tick();
      check_all("ar_after", 0, 0, 0, 0);

      // Latch held several cycles re-arms each time
      latch = 1'b1;
      in    = 32'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("hold_latch", 0, 3, 1, 0);
      end
      latch = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_all("post_hold", i, 3 - i, (i < 3), (i == 3));
      end

      check("carry_never", {31'd0, carry_seen}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_up_counter_match

`default_nettype wire
